// File: rtl/six_bit_signed_alu.sv
// six_bit_signed_alu: 6-bit two's-complement ALU (MUL / ADD / SUB / DIV) with a
// single registered result stage plus ovf / zero / dz status flags.
// Optional build macro: ALU_SATURATE_EN clamps overflowing results to the
// nearest representable value instead of letting them wrap.
module six_bit_signed_alu #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] s,
    output logic             out_valid,
    output logic             ovf,
    output logic             zero,
    output logic             dz
);

    localparam int FULL_W = 2 * WIDTH;

    // Signed range limits of the result, expressed at full internal width.
    localparam logic signed [FULL_W-1:0] MAX_VAL = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [FULL_W-1:0] MIN_VAL = {{(WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    logic signed [FULL_W-1:0] aExt;
    logic signed [FULL_W-1:0] bExt;
    logic signed [FULL_W-1:0] fullResult;

    logic [WIDTH-1:0] s_d;
    logic             ovf_d;
    logic             zero_d;
    logic             dz_d;

    logic [WIDTH-1:0] s_q;
    logic             valid_q;
    logic             ovf_q;
    logic             zero_q;
    logic             dz_q;

    // Compute the exact result at double width so every op (including the
    // -32 / -1 quotient) can be range-checked against the 6-bit signed window.
    always_comb begin
        aExt       = $signed({{WIDTH{a[WIDTH-1]}}, a});
        bExt       = $signed({{WIDTH{b[WIDTH-1]}}, b});
        fullResult = '0;
        dz_d       = 1'b0;
        case (op)
            OP_MUL: fullResult = aExt * bExt;
            OP_ADD: fullResult = aExt + bExt;
            OP_SUB: fullResult = aExt - bExt;
            OP_DIV: begin
                if (b == '0) begin
                    dz_d = 1'b1;
                end else begin
                    fullResult = aExt / bExt;
                end
            end
            default: fullResult = '0;
        endcase

        ovf_d = (fullResult > MAX_VAL) || (fullResult < MIN_VAL);
        s_d   = fullResult[WIDTH-1:0];
`ifdef ALU_SATURATE_EN
        // An overflowing result is never zero, so its sign bit alone tells
        // which rail to clamp to.
        if (ovf_d) begin
            if (!fullResult[FULL_W-1]) begin
                s_d = {1'b0, {(WIDTH - 1){1'b1}}};
            end else begin
                s_d = {1'b1, {(WIDTH - 1){1'b0}}};
            end
        end
`endif
        zero_d = (s_d == '0);
    end

    // Output stage: capture a new result on in_valid, otherwise hold it and
    // drop out_valid; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else if (in_valid) begin
            s_q     <= s_d;
            valid_q <= 1'b1;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            dz_q    <= dz_d;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign s         = s_q;
    assign out_valid = valid_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_six_bit_signed_alu.sv
// tb_six_bit_signed_alu: table-driven directed vectors, back-to-back and
// hold sequences, random vectors against an integer-arithmetic reference,
// and reset-priority checks for six_bit_signed_alu.
module tb_six_bit_signed_alu;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [5:0] a;
    logic [5:0] b;
    logic [1:0] op;
    logic [5:0] s;
    logic       out_valid;
    logic       ovf;
    logic       zero;
    logic       dz;

    int passCount;
    int totalCount;

    typedef struct {
        logic [5:0] a;
        logic [5:0] b;
        logic [1:0] op;
        logic [5:0] expS;
        logic       expOvf;
        logic       expZero;
        logic       expDz;
    } vec_t;

    vec_t vecs[12];

    logic [5:0] heldS;
    logic       heldOvf;
    logic       heldZero;
    logic       heldDz;

    six_bit_signed_alu dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .op        (op),
        .s         (s),
        .out_valid (out_valid),
        .ovf       (ovf),
        .zero      (zero),
        .dz        (dz)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: exact integer result, then range check, then wrap or clamp.
    function automatic void refModel(input logic [5:0] ra, input logic [5:0] rb,
                                     input logic [1:0] rop, output logic [5:0] es,
                                     output logic eo, output logic ez, output logic ed);
        int av;
        int bv;
        int trueVal;
        av = $signed(ra);
        bv = $signed(rb);
        ed = 1'b0;
        case (rop)
            2'd0: trueVal = av * bv;
            2'd1: trueVal = av + bv;
            2'd2: trueVal = av - bv;
            default: begin
                if (bv == 0) begin
                    trueVal = 0;
                    ed      = 1'b1;
                end else begin
                    trueVal = av / bv;
                end
            end
        endcase
        eo = (trueVal > 31) || (trueVal < -32);
        es = trueVal[5:0];
`ifdef ALU_SATURATE_EN
        if (eo) es = (trueVal > 0) ? 6'b011111 : 6'b100000;
`endif
        ez = (es == 6'd0);
    endfunction

    task automatic applyStimulus(input logic r, input logic v, input logic [5:0] ai,
                                 input logic [5:0] bi, input logic [1:0] opi);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        a        = ai;
        b        = bi;
        op       = opi;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOne(input string name, input logic [5:0] act, input logic [5:0] exp);
        totalCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end else begin
            passCount++;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [5:0] expS, input logic expOvf,
                               input logic expZero, input logic expDz, input logic expValid);
        checkOne({tag, ".s"}, s, expS);
        checkOne({tag, ".ovf"}, {5'd0, ovf}, {5'd0, expOvf});
        checkOne({tag, ".zero"}, {5'd0, zero}, {5'd0, expZero});
        checkOne({tag, ".dz"}, {5'd0, dz}, {5'd0, expDz});
        checkOne({tag, ".out_valid"}, {5'd0, out_valid}, {5'd0, expValid});
    endtask

    // Main sequence: reset, directed table, back-to-back/hold, random, reset again.
    initial begin
        logic [5:0] es;
        logic       eo;
        logic       ez;
        logic       ed;
        logic       v;
        logic [5:0] ra;
        logic [5:0] rb;
        logic [1:0] rop;

        passCount  = 0;
        totalCount = 0;
        rst        = 1'b1;
        in_valid   = 1'b1;
        a          = 6'd5;
        b          = 6'd6;
        op         = 2'd1;

`ifdef ALU_SATURATE_EN
        vecs[0]  = '{6'b101010, 6'b010101, 2'd0, 6'b100000, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{6'd31,     6'd1,      2'd1, 6'b011111, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{6'b100000, 6'b111111, 2'd3, 6'b011111, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{6'b100000, 6'd1,      2'd2, 6'b100000, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{6'b100000, 6'b100000, 2'd0, 6'b011111, 1'b1, 1'b0, 1'b0};
`else
        vecs[0]  = '{6'b101010, 6'b010101, 2'd0, 6'b110010, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{6'd31,     6'd1,      2'd1, 6'b100000, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{6'b100000, 6'b111111, 2'd3, 6'b100000, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{6'b100000, 6'd1,      2'd2, 6'b011111, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{6'b100000, 6'b100000, 2'd0, 6'b000000, 1'b1, 1'b1, 1'b0};
`endif
        vecs[1]  = '{6'd5,      6'd6,      2'd1, 6'd11,     1'b0, 1'b0, 1'b0};
        vecs[3]  = '{6'd5,      6'd6,      2'd2, 6'b111111, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{6'd7,      6'd7,      2'd2, 6'd0,      1'b0, 1'b1, 1'b0};
        vecs[5]  = '{6'd5,      6'd4,      2'd3, 6'd1,      1'b0, 1'b0, 1'b0};
        vecs[6]  = '{6'b111001, 6'd2,      2'd3, 6'b111101, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{6'd4,      6'd0,      2'd3, 6'd0,      1'b0, 1'b1, 1'b1};
        vecs[9]  = '{6'b100000, 6'b111111, 2'd2, 6'b100001, 1'b0, 1'b0, 1'b0};

        // Reset held two cycles with in_valid high must leave everything cleared.
        applyStimulus(1'b1, 1'b1, 6'd5, 6'd6, 2'd1);
        applyStimulus(1'b1, 1'b1, 6'd31, 6'd1, 2'd1);
        checkOutput("reset", 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Directed table: one valid cycle per vector, then an idle hold cycle.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
            checkOutput($sformatf("vec%0d", i), vecs[i].expS, vecs[i].expOvf,
                        vecs[i].expZero, vecs[i].expDz, 1'b1);
            applyStimulus(1'b0, 1'b0, 6'd3, 6'd3, 2'd1);
            checkOutput($sformatf("vec%0d_hold", i), vecs[i].expS, vecs[i].expOvf,
                        vecs[i].expZero, vecs[i].expDz, 1'b0);
        end

        // Back-to-back ADD / SUB / MUL, then an idle cycle that must hold.
        applyStimulus(1'b0, 1'b1, 6'd5, 6'd6, 2'd1);
        checkOutput("b2b_add", 6'd11, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 6'd7, 6'd7, 2'd2);
        checkOutput("b2b_sub", 6'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 6'b111101, 6'd3, 2'd0);
        checkOutput("b2b_mul", 6'b110111, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 6'd1, 6'd1, 2'd1);
        checkOutput("b2b_hold", 6'b110111, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random vectors with occasional idle cycles against the reference.
        heldS    = 6'b110111;
        heldOvf  = 1'b0;
        heldZero = 1'b0;
        heldDz   = 1'b0;
        for (int i = 0; i < 300; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            ra  = 6'($urandom);
            rb  = (($urandom_range(0, 15)) == 0) ? 6'd0 : 6'($urandom);
            rop = 2'($urandom);
            if (v) begin
                refModel(ra, rb, rop, es, eo, ez, ed);
                heldS    = es;
                heldOvf  = eo;
                heldZero = ez;
                heldDz   = ed;
            end
            applyStimulus(1'b0, v, ra, rb, rop);
            checkOutput($sformatf("rand%0d", i), heldS, heldOvf, heldZero, heldDz, v);
        end

        // Reset mid-stream with in_valid high still clears the outputs.
        applyStimulus(1'b0, 1'b1, 6'd31, 6'd1, 2'd1);
        applyStimulus(1'b1, 1'b1, 6'd31, 6'd1, 2'd1);
        checkOutput("reset2", 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
